// File: rtl/fifo_stream_reader_pkg.sv
// fifo_stream_reader_pkg: shared state encoding and FIFO timing constants
package fifo_stream_reader_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
  localparam int FIFO_RD_LAT = 1;
endpackage

// File: rtl/stream_skid_buf.sv
// stream_skid_buf: 2-entry buffer; head is the oldest word, tail the second
module stream_skid_buf #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   occ
);
  logic [W-1:0] tail;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (wr_en && (occ == 2'd0 || (occ == 2'd1 && pop))) head <= wr_data;
      else if (pop && occ == 2'd2) head <= tail;
      if (wr_en && ((occ == 2'd1 && !pop) || (occ == 2'd2 && pop))) tail <= wr_data;
      occ <= occ + 2'(wr_en) - 2'(pop);
    end
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops a sync FIFO into a framed valid/ready stream
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int FRAME_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_re,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  output logic             busy,
  output logic [15:0]      word_cnt
);
  state_t       state, state_nx;
  logic         inflight, en_pend, pop, drained, tag_last;
  logic [15:0]  tag_cnt;
  logic [1:0]   occ;
  logic [WIDTH:0] head;
  assign pop      = m_valid & m_ready;
  assign m_valid  = occ != 2'd0;
  assign m_data   = head[WIDTH:1];
  assign m_last   = head[0] & m_valid;
  assign drained  = (occ == 2'd0) & ~inflight;
  assign busy     = (state != IDLE) | m_valid | inflight;
  assign tag_last = tag_cnt == 16'(FRAME_LEN - 1);
  // Credit counts the slot freed by this cycle's pop, giving 1 word/clk under m_ready=1
  assign fifo_re  = (state == RUN) & ~fifo_empty &
                    (({1'b0, occ} - {2'b0, pop} + {2'b0, inflight}) < 3'd2);
  always_comb
    state_nx = state == IDLE ? (en ? RUN : IDLE) :
               state == RUN  ? (en ? RUN : DRAIN) :
               drained       ? ((en | en_pend) ? RUN : IDLE) : DRAIN;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      inflight <= 1'b0;
      en_pend  <= 1'b0;
      tag_cnt  <= '0;
      word_cnt <= '0;
    end else begin
      state    <= state_nx;
      inflight <= fifo_re;
      en_pend  <= (state == DRAIN) & (en_pend | en) & ~drained;
      if (inflight) tag_cnt <= tag_last ? 16'd0 : tag_cnt + 16'd1;
      if (pop) word_cnt <= word_cnt + 16'd1;
    end
  // Words are tagged with m_last as they enter, so the buffer carries data+last
  stream_skid_buf #(.W(WIDTH + 1)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (inflight),
    .wr_data ({fifo_dout, tag_last}),
    .pop     (pop),
    .head    (head),
    .occ     (occ)
  );
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed vectors against a queue-based FIFO model
module tb_fifo_stream_reader;
  logic        clk = 0, rst_n = 1, en = 0, fifo_empty = 1, m_ready = 0;
  logic [15:0] fifo_dout = '0;
  logic        fifo_re, m_valid, m_last, busy;
  logic [15:0] m_data, word_cnt;
  logic [15:0] fq[$];
  logic [16:0] rx[$];
  int          vec = 0, bad = 0, re_cnt = 0, viol = 0;
  bit          mon = 1;
  logic        s_re, s_vld, s_last;
  logic [15:0] s_data;
  typedef struct {
    logic en, rdy, re, vld;
    logic [15:0] data;
    logic last;
  } vec_t;
  vec_t tv[12];

  fifo_stream_reader #(.WIDTH(16), .FRAME_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_re(fifo_re), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready), .busy(busy), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (fifo_re && fq.size() > 0) fifo_dout <= fq.pop_front();

  task automatic chk(input string n, input int act, input int exp);
    vec++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", n, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] v);
    fq.push_back(v);
    fifo_empty = 0;
  endtask

  task automatic cyc();
    @(negedge clk);
    s_re = fifo_re; s_vld = m_valid; s_data = m_data; s_last = m_last;
    if (fifo_re && fifo_empty) viol++;
    if (fifo_re) re_cnt++;
    if (mon && m_valid && m_ready) rx.push_back({m_last, m_data});
    @(posedge clk);
    #1;
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic do_reset();
    rst_n = 0; en = 0; m_ready = 0; mon = 1; re_cnt = 0;
    fq.delete(); rx.delete();
    @(posedge clk);
    #1;
    rst_n = 1;
    fifo_empty = 1;
  endtask

  initial begin
    tv[0]  = '{1, 1, 0, 0, 16'd0, 0};
    tv[1]  = '{1, 1, 1, 0, 16'd0, 0};
    tv[2]  = '{1, 1, 1, 0, 16'd0, 0};
    tv[3]  = '{1, 1, 1, 1, 16'd1, 0};
    tv[4]  = '{1, 1, 1, 1, 16'd2, 0};
    tv[5]  = '{1, 1, 1, 1, 16'd3, 0};
    tv[6]  = '{1, 1, 1, 1, 16'd4, 1};
    tv[7]  = '{1, 1, 1, 1, 16'd5, 0};
    tv[8]  = '{1, 1, 1, 1, 16'd6, 0};
    tv[9]  = '{1, 1, 0, 1, 16'd7, 0};
    tv[10] = '{1, 1, 0, 1, 16'd8, 1};
    tv[11] = '{1, 1, 0, 0, 16'd0, 0};
    #1 rst_n = 0;
    #1;
    chk("rst_re", fifo_re, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", word_cnt, 0);
    @(posedge clk);
    #1 rst_n = 1;
    for (int v = 1; v <= 8; v++) push(16'(v));
    for (int i = 0; i < 12; i++) begin
      en = tv[i].en;
      m_ready = tv[i].rdy;
      cyc();
      chk($sformatf("t1_re[%0d]", i), s_re, tv[i].re);
      chk($sformatf("t1_valid[%0d]", i), s_vld, tv[i].vld);
      if (tv[i].vld) begin
        chk($sformatf("t1_data[%0d]", i), s_data, tv[i].data);
        chk($sformatf("t1_last[%0d]", i), s_last, tv[i].last);
      end
    end
    chk("t1_cnt", word_cnt, 8);

    do_reset();
    en = 1;
    for (int v = 1; v <= 5; v++) push(16'(v));
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (s_vld) chk("t2_hold_data", s_data, 1);
    end
    chk("t2_reads", re_cnt, 2);
    chk("t2_hold_valid", m_valid, 1);
    m_ready = 1;
    for (int k = 0; k < 30 && rx.size() < 5; k++) cyc();
    repeat (3) cyc();
    chk("t2_count", rx.size(), 5);
    for (int i = 0; i < rx.size() && i < 5; i++) begin
      chk($sformatf("t2_data[%0d]", i), rx[i][15:0], i + 1);
      chk($sformatf("t2_last[%0d]", i), rx[i][16], i == 3);
    end
    chk("t2_cnt", word_cnt, 5);

    do_reset();
    en = 1; m_ready = 1;
    push(16'd1); push(16'd2);
    repeat (16) cyc();
    push(16'd3); push(16'd4);
    for (int k = 0; k < 20 && rx.size() < 4; k++) cyc();
    chk("t3_count", rx.size(), 4);
    for (int i = 0; i < rx.size() && i < 4; i++) begin
      chk($sformatf("t3_data[%0d]", i), rx[i][15:0], i + 1);
      chk($sformatf("t3_last[%0d]", i), rx[i][16], i == 3);
    end

    do_reset();
    en = 1;
    push(16'd10); push(16'd11); push(16'd12);
    repeat (6) cyc();
    chk("t4_valid", m_valid, 1);
    chk("t4_data", m_data, 10);
    en = 0; re_cnt = 0;
    repeat (4) cyc();
    chk("t4_no_reads", re_cnt, 0);
    chk("t4_busy", busy, 1);
    chk("t4_held", rx.size(), 0);
    m_ready = 1;
    repeat (6) cyc();
    chk("t4_count", rx.size(), 2);
    if (rx.size() == 2) begin
      chk("t4_data0", rx[0][15:0], 10);
      chk("t4_data1", rx[1][15:0], 11);
    end
    chk("t4_idle", busy, 0);
    chk("t4_no_reads2", re_cnt, 0);
    chk("t4_fifo_left", fq.size(), 1);

    do_reset();
    en = 1; m_ready = 1;
    for (int v = 1; v <= 9; v++) push(16'(v));
    repeat (4) cyc();
    chk("t5_pre_valid", m_valid, 1);
    chk("t5_pre_cnt", word_cnt, 1);
    #2 rst_n = 0;
    #1;
    chk("t5_async_valid", m_valid, 0);
    chk("t5_async_re", fifo_re, 0);
    chk("t5_async_cnt", word_cnt, 0);
    chk("t5_async_busy", busy, 0);
    @(posedge clk);
    #1 rst_n = 1;
    rx.delete();
    fifo_empty = (fq.size() == 0);
    for (int k = 0; k < 30 && rx.size() < 6; k++) cyc();
    chk("t5_count", rx.size(), 6);
    for (int i = 0; i < rx.size() && i < 6; i++) begin
      chk($sformatf("t5_data[%0d]", i), rx[i][15:0], i + 4);
      chk($sformatf("t5_last[%0d]", i), rx[i][16], i == 3);
    end

    do_reset();
    en = 1; m_ready = 1; mon = 0;
    for (int i = 0; i < 65600; i++) push(16'(i));
    for (int k = 0; k < 70000 && word_cnt !== 16'hffff; k++) cyc();
    chk("t6_max", word_cnt, 65535);
    chk("t6_valid", m_valid, 1);
    cyc();
    chk("t6_wrap", word_cnt, 0);

    chk("no_re_when_empty", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
